// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op encodings and default widths.
package pc_seq_pkg;

  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_INC  = 3'b001,
    OP_JMP  = 3'b010,
    OP_JZ   = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101
  } op_e;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO; the count is the only reset state.
// Pushes into a full stack and pops from an empty stack are ignored.
module ret_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_push_data,
  output logic [W-1:0]  o_top,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage is sized up to a power of two so the index width matches exactly.
  logic [W-1:0]  r_mem [2**IW];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_countM1;
  logic [IW-1:0] w_pushIdx;
  logic [IW-1:0] w_topIdx;
  logic          w_doPush;
  logic          w_doPop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_doPush  = i_push && !o_full;
  assign w_doPop   = i_pop && !o_empty && !i_push;
  assign w_countM1 = r_count - CW'(1);
  assign w_pushIdx = r_count[IW-1:0];
  assign w_topIdx  = w_countM1[IW-1:0];
  assign o_top     = r_mem[w_topIdx];
  assign o_count   = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (w_doPush) begin
      r_count <= r_count + CW'(1);
    end else if (w_doPop) begin
      r_count <= w_countM1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_doPush) begin
      r_mem[w_pushIdx] <= i_push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// 8-bit program counter feeding MUX1 In1, with call/return stack and sticky
// overflow/underflow flags.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W      = ADDR_W_DEF,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              SPW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_cond,
  input  logic              i_clr_err,
  output logic [ADDR_W-1:0] o_pc,
  output logic [SPW-1:0]    o_sp,
  output logic              o_stack_full,
  output logic              o_stack_empty,
  output logic              o_ovf_err,
  output logic              o_unf_err
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_ovf;
  logic              r_unf;
  logic [ADDR_W-1:0] w_pcInc;
  logic [ADDR_W-1:0] w_pcNext;
  logic [ADDR_W-1:0] w_top;
  logic              w_push;
  logic              w_pop;
  logic              w_setOvf;
  logic              w_setUnf;
  logic              w_full;
  logic              w_empty;

  assign w_pcInc = r_pc + ADDR_W'(1);

  ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH),
    .CW    (SPW)
  ) u_stack (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pcInc),
    .o_top       (w_top),
    .o_count     (o_sp),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Everything is gated by enable here so the stack never sees a disabled op.
  always_comb begin
    w_pcNext = r_pc;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_setOvf = 1'b0;
    w_setUnf = 1'b0;
    if (i_en) begin
      case (i_op)
        OP_INC:  w_pcNext = w_pcInc;
        OP_JMP:  w_pcNext = i_target;
        OP_JZ:   w_pcNext = i_cond ? i_target : w_pcInc;
        OP_CALL: begin
          if (w_full) begin
            w_setOvf = 1'b1;
          end else begin
            w_push   = 1'b1;
            w_pcNext = i_target;
          end
        end
        OP_RET: begin
          if (w_empty) begin
            w_setUnf = 1'b1;
          end else begin
            w_pop    = 1'b1;
            w_pcNext = w_top;
          end
        end
        default: w_pcNext = r_pc;
      endcase
    end
  end

  // A flag being set in the same cycle as clr_err stays set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc  <= RESET_VEC;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_pcNext;
      r_ovf <= w_setOvf | (r_ovf & ~i_clr_err);
      r_unf <= w_setUnf | (r_unf & ~i_clr_err);
    end
  end

  assign o_pc          = r_pc;
  assign o_stack_full  = w_full;
  assign o_stack_empty = w_empty;
  assign o_ovf_err     = r_ovf;
  assign o_unf_err     = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rstN;
  logic       en;
  logic [2:0] op;
  logic [7:0] target;
  logic       cond;
  logic       clrErr;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       stackFull;
  logic       stackEmpty;
  logic       ovfErr;
  logic       unfErr;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_VEC   (8'h00)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_en          (en),
    .i_op          (op),
    .i_target      (target),
    .i_cond        (cond),
    .i_clr_err     (clrErr),
    .o_pc          (pc),
    .o_sp          (sp),
    .o_stack_full  (stackFull),
    .o_stack_empty (stackEmpty),
    .o_ovf_err     (ovfErr),
    .o_unf_err     (unfErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [7:0] ePc, input logic [2:0] eSp,
                            input logic eOvf, input logic eUnf);
    checkOutput({tag, ".pc"},    32'(pc),         32'(ePc));
    checkOutput({tag, ".sp"},    32'(sp),         32'(eSp));
    checkOutput({tag, ".full"},  32'(stackFull),  32'(eSp == 3'd4));
    checkOutput({tag, ".empty"}, 32'(stackEmpty), 32'(eSp == 3'd0));
    checkOutput({tag, ".ovf"},   32'(ovfErr),     32'(eOvf));
    checkOutput({tag, ".unf"},   32'(unfErr),     32'(eUnf));
  endtask

  // Inputs change on the falling edge; results are sampled 1ns after the rising edge.
  task automatic applyStimulus(input logic aEn, input logic [2:0] aOp, input logic [7:0] aTgt,
                               input logic aCond, input logic aClr);
    @(negedge clk);
    en     = aEn;
    op     = aOp;
    target = aTgt;
    cond   = aCond;
    clrErr = aClr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0; en = 1'b0; op = OP_HOLD; target = 8'h00; cond = 1'b0; clrErr = 1'b0;
    #12;
    checkState("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(1'b1, OP_INC, 8'h00, 1'b0, 1'b0);
    checkState("inc1", 8'h01, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_INC, 8'h00, 1'b0, 1'b0);
    checkState("inc2", 8'h02, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_INC, 8'h00, 1'b0, 1'b0);
    checkState("inc3", 8'h03, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_CALL, 8'h50, 1'b0, 1'b0);
    checkState("preRstCall", 8'h50, 3'd1, 1'b0, 1'b0);

    #2;
    rstN = 1'b0;
    #1;
    checkState("asyncRst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkState("rstHeld", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    en = 1'b0;
    rstN = 1'b1;

    applyStimulus(1'b1, OP_JMP, 8'hFE, 1'b0, 1'b0);
    checkOutput("jmpFE", 32'(pc), 32'h00FE);
    applyStimulus(1'b1, OP_INC, 8'h00, 1'b0, 1'b0);
    checkOutput("incFF", 32'(pc), 32'h00FF);
    applyStimulus(1'b1, OP_INC, 8'h00, 1'b0, 1'b0);
    checkOutput("wrap00", 32'(pc), 32'h0000);
    applyStimulus(1'b1, OP_JZ, 8'h40, 1'b0, 1'b0);
    checkOutput("jzNotTaken", 32'(pc), 32'h0001);
    applyStimulus(1'b1, OP_JZ, 8'h40, 1'b1, 1'b0);
    checkOutput("jzTaken", 32'(pc), 32'h0040);
    applyStimulus(1'b1, 3'b110, 8'h99, 1'b1, 1'b0);
    checkState("reserved6", 8'h40, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b111, 8'h99, 1'b1, 1'b0);
    checkState("reserved7", 8'h40, 3'd0, 1'b0, 1'b0);

    applyStimulus(1'b1, OP_JMP, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_CALL, 8'h20, 1'b0, 1'b0);
    checkState("call20", 8'h20, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_CALL, 8'h30, 1'b0, 1'b0);
    checkState("call30", 8'h30, 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_RET, 8'h00, 1'b0, 1'b0);
    checkState("ret21", 8'h21, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_RET, 8'h00, 1'b0, 1'b0);
    checkState("ret11", 8'h11, 3'd0, 1'b0, 1'b0);

    applyStimulus(1'b1, OP_CALL, 8'h60, 1'b0, 1'b0);
    checkState("ovfCall1", 8'h60, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_CALL, 8'h70, 1'b0, 1'b0);
    checkState("ovfCall2", 8'h70, 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_CALL, 8'h80, 1'b0, 1'b0);
    checkState("ovfCall3", 8'h80, 3'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_CALL, 8'h90, 1'b0, 1'b0);
    checkState("ovfCall4", 8'h90, 3'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_CALL, 8'h77, 1'b0, 1'b0);
    checkState("ovfCall5", 8'h90, 3'd4, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_RET, 8'h00, 1'b0, 1'b0);
    checkState("ovfRet1", 8'h81, 3'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_RET, 8'h00, 1'b0, 1'b0);
    checkState("ovfRet2", 8'h71, 3'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_RET, 8'h00, 1'b0, 1'b0);
    checkState("ovfRet3", 8'h61, 3'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_RET, 8'h00, 1'b0, 1'b0);
    checkState("ovfRet4", 8'h12, 3'd0, 1'b1, 1'b0);

    applyStimulus(1'b1, OP_RET, 8'h00, 1'b0, 1'b0);
    checkState("unfRet", 8'h12, 3'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, OP_HOLD, 8'h00, 1'b0, 1'b1);
    checkState("clrHold", 8'h12, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_RET, 8'h00, 1'b0, 1'b1);
    checkState("clrVsUnf", 8'h12, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, OP_HOLD, 8'h00, 1'b0, 1'b0);
    checkState("flagSticky", 8'h12, 3'd0, 1'b0, 1'b1);

    applyStimulus(1'b0, OP_CALL, 8'h55, 1'b0, 1'b0);
    checkState("enOffCall", 8'h12, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, OP_RET, 8'h55, 1'b0, 1'b1);
    checkState("enOffClr", 8'h12, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_JMP, 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_CALL, 8'h33, 1'b0, 1'b0);
    checkState("callAtFF", 8'h33, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_RET, 8'h00, 1'b0, 1'b0);
    checkState("retWrap", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- 8-bit program counter with a small hardware return-address stack.
- Generates the instruction address that feeds the address-select MUX1 as its In1 input. MUX1 chooses between the PC and the operand/data address.
- Executes one sequencing operation per enabled cycle: hold, increment, jump, conditional jump, call or return.
- Reports stack overflow and underflow through sticky error flags.

Parameters:
- ADDR_W, 8, width of the PC, the target address and each stack entry.
- STACK_DEPTH, 4, number of return-address entries. Must be 2..16.
- RESET_VEC, 8'h00, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  advance enable; when 0, all state holds.
- op  input  3  sequencing operation (encodings under Decomposition).
- target  input  ADDR_W  jump or call destination.
- cond  input  1  condition for JZ (1 = taken).
- clr_err  input  1  synchronous clear of both sticky error flags.
- pc  output  ADDR_W  current instruction address, registered.
- sp  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  combinational: sp == STACK_DEPTH.
- stack_empty  output  1  combinational: sp == 0.
- ovf_err  output  1  sticky: a CALL was attempted with the stack full.
- unf_err  output  1  sticky: a RET was attempted with the stack empty.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_VEC, sp=0, ovf_err=0, unf_err=0.
  - Stack contents are don't-care.
  - Reset asserted mid-operation aborts the op; no partial push or pop survives.
- en=0: pc, sp, stack and flags hold. clr_err is still honoured.
- en=1: one op takes effect at the rising edge. New pc is visible the cycle after the edge (1-cycle latency).
- All PC arithmetic is modulo 2^ADDR_W (8'hFF+1 = 8'h00).
- Op behaviour:
  - HOLD: no change.
  - INC: pc <= pc+1.
  - JMP: pc <= target.
  - JZ: if cond, pc <= target; otherwise pc <= pc+1.
  - CALL, not full: stack[sp] <= pc+1 (wrapped), sp <= sp+1, pc <= target.
  - CALL, full: no push, sp unchanged, pc unchanged, ovf_err <= 1.
  - RET, not empty: pc <= stack[sp-1], sp <= sp-1.
  - RET, empty: pc unchanged, sp unchanged, unf_err <= 1.
  - Reserved codes (3'b110, 3'b111): treated as HOLD; no flag change.
- Error flags:
  - Once set, stay set until clr_err=1.
  - clr_err and a new error in the same cycle: the error wins and the flag is 1 after the edge.
  - clr_err clears only flags not being set in that cycle.
- Back-to-back CALL then RET returns to the CALL address+1 with no bubble.
- Alternating CALL/RET at sp boundaries must never corrupt sp. Legal range is 0..STACK_DEPTH.
- No FSM beyond the sp counter. Stack storage is plain registers; no RAM inference is required.

Decomposition:
- Shared package pc_seq_pkg holds:
  - op encodings: OP_HOLD=3'b000, OP_INC=3'b001, OP_JMP=3'b010, OP_JZ=3'b011, OP_CALL=3'b100, OP_RET=3'b101;
  - ADDR_W default.
- One sub-module, ret_stack:
  - parameterised LIFO with push, pop, push_data, top, count, full and empty;
  - asynchronous active-low reset on count;
  - push when full and pop when empty are ignored internally.
- pc_sequencer owns pc, the op decode and the error flags.

Test Plan:
- Reset and increment: rst_n low then high, en=1, op=INC for 3 cycles -> pc 00,01,02,03. Assert rst_n low mid-run -> pc=00 immediately, sp=0.
- Wrap and jump: JMP target=FE, then INC x2 -> pc FE,FF,00. JZ target=40 with cond=0 -> pc=01; with cond=1 -> pc=40.
- Nested calls:
  - Starting at pc=10: CALL 20 -> pc=20, sp=1.
  - CALL 30 -> pc=30, sp=2.
  - RET -> pc=21, sp=1.
  - RET -> pc=11, sp=0, stack_empty=1.
- Overflow (STACK_DEPTH=4): CALL x4 -> sp=4, stack_full=1. Fifth CALL target=77 -> pc unchanged, sp=4, ovf_err=1. Four RETs still return correct addresses.
- Underflow and clear:
  - RET at sp=0 -> pc unchanged, unf_err=1.
  - clr_err=1 with op=HOLD -> unf_err=0.
  - clr_err=1 with RET at sp=0 in the same cycle -> unf_err stays 1.
- Enable gating: en=0 with op=CALL target=55 -> pc, sp and flags unchanged. Call at pc=FF with en=1 -> pushed return address = 00.
